// File: rtl/invader_fleet_ctrl_pkg.sv
// Shared types and constants for the invader fleet controller.
// FSM states, fleet geometry, screen limits, 12-bit edge math.
package invader_fleet_ctrl_pkg;

  localparam int COLS        = 8;
  localparam int ROWS        = 4;
  localparam int COL_PITCH   = 40;
  localparam int INV_W       = 32;
  localparam int LEFT_LIMIT  = 8;
  localparam int RIGHT_LIMIT = 620;

  typedef logic [11:0] edge_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    CHECK
  } fsm_t;

  function automatic edge_t colOffset(
    input logic [2:0] col
  );
    return edge_t'(col) * edge_t'(COL_PITCH);
  endfunction

endpackage

// File: rtl/invader_fleet_ctrl_popcount.sv
// Registered population count of the alive mask.
// Ports: clk, resetN, bits[31:0] in; count[5:0] out (one cycle late).
module fleet_popcount (
  input  logic        clk,
  input  logic        resetN,
  input  logic [31:0] bits,
  output logic [5:0]  count
);

  logic [5:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 32; i++) begin
      sum = sum + 6'(bits[i]);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) count <= 6'd32;
    else         count <= sum;
  end

endmodule

// File: rtl/invader_fleet_ctrl.sv
// Invader fleet controller: alive mask, count, edge detect, chgDir.
// Ports: clk, resetN, startOfFrame, topLeftX, hit*, newWave in;
//        aliveMask, aliveCount, allDead, chgDir, movingRight out.
module invader_fleet_ctrl
  import invader_fleet_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] topLeftX,
  input  logic        hitValid,
  input  logic [1:0]  hitRow,
  input  logic [2:0]  hitCol,
  input  logic        newWave,
  output logic [31:0] aliveMask,
  output logic [5:0]  aliveCount,
  output logic        allDead,
  output logic        chgDir,
  output logic        movingRight
);

  fsm_t        state;
  fsm_t        nextState;
  logic [2:0]  idx;
  logic [7:0]  occ;
  logic [7:0]  occNow;
  logic [10:0] curX;
  logic [10:0] prevX;
  logic [2:0]  minCol;
  logic [2:0]  maxCol;
  logic        found;
  logic        holdoff;
  logic        sample;
  logic        newRight;
  logic        edgeHit;
  logic        fire;
  edge_t       rightEdge;
  edge_t       leftEdge;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)            aliveMask <= '1;
    else if (newWave)       aliveMask <= '1;
    else if (hitValid)
      aliveMask[{hitRow, hitCol}] <= 1'b0;
  end

  fleet_popcount uPop (
    .clk    (clk),
    .resetN (resetN),
    .bits   (aliveMask),
    .count  (aliveCount)
  );

  assign allDead = (aliveCount == 6'd0);

  always_comb begin
    occNow = '0;
    for (int c = 0; c < COLS; c++) begin
      occNow[c] = aliveMask[c]      | aliveMask[8 + c]
                | aliveMask[16 + c] | aliveMask[24 + c];
    end
  end

  assign sample = (state == IDLE) && startOfFrame;

  always_comb begin
    newRight = movingRight;
    if (topLeftX > prevX)      newRight = 1'b1;
    else if (topLeftX < prevX) newRight = 1'b0;
  end

  assign rightEdge = edge_t'(curX) + colOffset(maxCol)
                   + edge_t'(INV_W);
  assign leftEdge  = edge_t'(curX) + colOffset(minCol);

  assign edgeHit =
    ( movingRight && rightEdge >= edge_t'(RIGHT_LIMIT)) ||
    (!movingRight && leftEdge  <= edge_t'(LEFT_LIMIT));

  assign fire = (state == CHECK) && edgeHit
             && !holdoff && (occ != 8'd0);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startOfFrame) nextState = SCAN;
      SCAN:    if (idx == 3'd7)  nextState = CHECK;
      CHECK:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      chgDir      <= 1'b0;
      movingRight <= 1'b1;
      holdoff     <= 1'b0;
      prevX       <= '0;
      curX        <= '0;
      minCol      <= 3'd0;
      maxCol      <= 3'd7;
      occ         <= '0;
      idx         <= '0;
      found       <= 1'b0;
    end else begin
      chgDir <= fire;
      if (sample) begin
        curX        <= topLeftX;
        prevX       <= topLeftX;
        occ         <= occNow;
        movingRight <= newRight;
        idx         <= '0;
        found       <= 1'b0;
        if (newRight != movingRight) holdoff <= 1'b0;
      end else if (state == SCAN) begin
        idx <= idx + 3'd1;
        if (occ[idx]) begin
          maxCol <= idx;
          if (!found) begin
            minCol <= idx;
            found  <= 1'b1;
          end
        end
      end
      if (fire) holdoff <= 1'b1;
    end
  end

endmodule

// File: tb/tb_invader_fleet_ctrl.sv
// Self-checking bench for invader_fleet_ctrl.
// Frame table plus hand sequences, scoreboard queue of expectations.
module tb_invader_fleet_ctrl;

  logic        clk = 0;
  logic        resetN = 0;
  logic        startOfFrame = 0;
  logic [10:0] topLeftX = 0;
  logic        hitValid = 0;
  logic [1:0]  hitRow = 0;
  logic [2:0]  hitCol = 0;
  logic        newWave = 0;
  logic [31:0] aliveMask;
  logic [5:0]  aliveCount;
  logic        allDead;
  logic        chgDir;
  logic        movingRight;

  int total = 0;
  int bad   = 0;
  logic [31:0] expMask;

  typedef struct {
    logic [10:0] x;
    logic        expPulse;
    logic        expRight;
    logic        stray;
  } vec_t;

  typedef struct {
    logic expPulse;
    logic expRight;
  } exp_t;

  vec_t tbl[9];
  exp_t sbQ[$];

  invader_fleet_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .topLeftX     (topLeftX),
    .hitValid     (hitValid),
    .hitRow       (hitRow),
    .hitCol       (hitCol),
    .newWave      (newWave),
    .aliveMask    (aliveMask),
    .aliveCount   (aliveCount),
    .allDead      (allDead),
    .chgDir       (chgDir),
    .movingRight  (movingRight)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic doReset();
    resetN = 0;
    startOfFrame = 0;
    hitValid = 0;
    newWave = 0;
    repeat (3) @(posedge clk);
    #1 resetN = 1;
    expMask = '1;
  endtask

  task automatic checkResetOuts(input string tag);
    @(negedge clk);
    check({tag, ".mask"}, aliveMask, 32'hFFFF_FFFF);
    check({tag, ".count"}, 32'(aliveCount), 32);
    check({tag, ".allDead"}, 32'(allDead), 0);
    check({tag, ".chgDir"}, 32'(chgDir), 0);
    check({tag, ".right"}, 32'(movingRight), 1);
  endtask

  task automatic hit(input int r, input int c);
    @(posedge clk);
    #1;
    hitValid = 1;
    hitRow = 2'(r);
    hitCol = 3'(c);
    expMask[r * 8 + c] = 1'b0;
    @(posedge clk);
    #1 hitValid = 0;
  endtask

  task automatic checkMask(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(expMask[i]);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".mask"}, aliveMask, expMask);
    check({tag, ".count"}, 32'(aliveCount), n);
    check({tag, ".allDead"}, 32'(allDead), (n == 0) ? 1 : 0);
  endtask

  // A clean pulse seen only at cycle T+10 reports 1, silence
  // reports 0, anything else reports 2.
  task automatic runFrame(
    input logic [10:0] x,
    input logic        expPulse,
    input logic        expRight,
    input logic        stray
  );
    int hits;
    int first;
    int got;
    exp_t e;
    sbQ.push_back('{expPulse, expRight});
    @(posedge clk);
    #1;
    startOfFrame = 1;
    topLeftX = x;
    @(posedge clk);
    #1 startOfFrame = 0;
    hits = 0;
    first = 0;
    for (int k = 1; k <= 14; k++) begin
      if (stray && k == 3) begin
        startOfFrame = 1;
        topLeftX = 11'd400;
      end
      @(negedge clk);
      if (chgDir) begin
        hits++;
        if (first == 0) first = k;
      end
      @(posedge clk);
      #1;
      startOfFrame = 0;
      topLeftX = x;
    end
    got = (hits == 0) ? 0 : ((hits == 1 && first == 10) ? 1 : 2);
    e = sbQ.pop_front();
    check($sformatf("pulse@x%0d", x), 32'(got), 32'(e.expPulse));
    check($sformatf("right@x%0d", x), 32'(movingRight),
          32'(e.expRight));
  endtask

  initial begin
    tbl[0] = '{11'd300, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{11'd301, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{11'd307, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{11'd308, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{11'd309, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{11'd340, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{11'd348, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{11'd10,  1'b0, 1'b0, 1'b0};
    tbl[8] = '{11'd8,   1'b1, 1'b0, 1'b0};

    doReset();
    checkResetOuts("reset");

    for (int i = 0; i < 5; i++)
      runFrame(tbl[i].x, tbl[i].expPulse,
               tbl[i].expRight, tbl[i].stray);

    doReset();
    for (int r = 0; r < 4; r++) hit(r, 7);
    checkMask("col7dead");
    for (int i = 5; i < 9; i++)
      runFrame(tbl[i].x, tbl[i].expPulse,
               tbl[i].expRight, tbl[i].stray);
    hit(0, 7);
    checkMask("rehit");

    doReset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) hit(r, c);
    checkMask("alldead");
    runFrame(11'd700, 1'b0, 1'b1, 1'b0);
    runFrame(11'd0,   1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    newWave = 1;
    hitValid = 1;
    hitRow = 2'd2;
    hitCol = 3'd3;
    @(posedge clk);
    #1;
    newWave = 0;
    hitValid = 0;
    @(negedge clk);
    check("wave.mask", aliveMask, 32'hFFFF_FFFF);
    check("wave.countLag", 32'(aliveCount), 0);
    @(negedge clk);
    check("wave.count", 32'(aliveCount), 32);

    doReset();
    runFrame(11'd300, 1'b0, 1'b1, 1'b0);
    begin
      int seen;
      seen = 0;
      @(posedge clk);
      #1;
      startOfFrame = 1;
      topLeftX = 11'd308;
      @(posedge clk);
      #1 startOfFrame = 0;
      for (int k = 1; k <= 14; k++) begin
        if (k == 5) resetN = 0;
        @(negedge clk);
        if (chgDir) seen++;
        if (k == 5) begin
          check("abort.count", 32'(aliveCount), 32);
          check("abort.right", 32'(movingRight), 1);
        end
        @(posedge clk);
        #1;
        if (k == 7) resetN = 1;
      end
      check("abort.noPulse", 32'(seen), 0);
    end
    checkResetOuts("abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
